// File: rtl/axi_txn_sequencer_if.sv
// Per-channel INIT/DONE/ERROR bundle between the sequencer and two AXI masters.
interface axi_txn_sequencer_if;
  logic M00_AXI_INIT_AXI_TXN;
  logic M01_AXI_INIT_AXI_TXN;
  logic M00_AXI_TXN_DONE;
  logic M01_AXI_TXN_DONE;
  logic M00_AXI_ERROR;
  logic M01_AXI_ERROR;

  modport master (
    output M00_AXI_INIT_AXI_TXN,
    output M01_AXI_INIT_AXI_TXN,
    input  M00_AXI_TXN_DONE,
    input  M01_AXI_TXN_DONE,
    input  M00_AXI_ERROR,
    input  M01_AXI_ERROR
  );

  modport slave (
    input  M00_AXI_INIT_AXI_TXN,
    input  M01_AXI_INIT_AXI_TXN,
    output M00_AXI_TXN_DONE,
    output M01_AXI_TXN_DONE,
    output M00_AXI_ERROR,
    output M01_AXI_ERROR
  );
endinterface

// File: rtl/axi_txn_sequencer.sv
// Runs INIT pulses on two AXI master channels in order and reports status.
// Optional WAIT timeout enabled by defining AXI_TXN_SEQ_TIMEOUT_EN.
module axi_txn_sequencer #(
  parameter int GAP_CYCLES        = 20,
  parameter int INIT_PULSE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 4096
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          chan_en,
  axi_txn_sequencer_if.master txn,
  output logic                busy,
  output logic                seq_done,
  output logic                pass,
  output logic [1:0]          err_flags,
  output logic [1:0]          tmo_flags
);

  typedef enum logic [2:0] {
    IDLE, GAP, INIT, WAIT, REPORT
  } state_t;

  localparam logic [15:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam logic [15:0] INIT_LAST =
    16'(INIT_PULSE_CYCLES - 1);
  // A zero gap lands a new channel straight in INIT.
  localparam state_t CH_ENTRY =
    (GAP_CYCLES == 0) ? INIT : GAP;

  state_t      state, state_nxt;
  logic        ch, ch_nxt;
  logic        en1_q;
  logic [15:0] cnt;
  logic        done_cur, err_cur;
  logic        tmo_hit, wait_end, more, accept;
  logic [1:0]  err_n, tmo_n;

  assign done_cur = ch ? txn.M01_AXI_TXN_DONE
                       : txn.M00_AXI_TXN_DONE;
  assign err_cur  = ch ? txn.M01_AXI_ERROR
                       : txn.M00_AXI_ERROR;

`ifdef AXI_TXN_SEQ_TIMEOUT_EN
  localparam logic [19:0] TMO_LAST =
    20'(TIMEOUT_CYCLES - 1);
  logic [19:0] tmo_cnt;
  logic [1:0]  tmo_q;

  assign tmo_hit = (state == WAIT) && !done_cur &&
                   (tmo_cnt == TMO_LAST);

  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN)
      tmo_cnt <= '0;
    else if (state == WAIT && state_nxt == WAIT)
      tmo_cnt <= tmo_cnt + 20'd1;
    else
      tmo_cnt <= '0;

  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN)
      tmo_q <= '0;
    else if (accept)
      tmo_q <= '0;
    else if (wait_end && !abort)
      tmo_q <= tmo_n;

  always_comb begin
    tmo_n     = tmo_q;
    tmo_n[ch] = tmo_hit;
  end

  assign tmo_flags = tmo_q;
`else
  assign tmo_hit   = 1'b0;
  assign tmo_n     = 2'b00;
  assign tmo_flags = 2'b00;
`endif

  assign accept   = (state == IDLE) && start && !abort;
  assign wait_end = (state == WAIT) && (done_cur || tmo_hit);
  assign more     = !ch && en1_q;

  always_comb begin
    err_n     = err_flags;
    err_n[ch] = done_cur & err_cur;
  end

  // State register
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= IDLE;
      ch    <= 1'b0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
    end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    case (state)
      IDLE:
        if (accept) begin
          if (chan_en == 2'b00) begin
            state_nxt = REPORT;
          end else begin
            ch_nxt    = !chan_en[0];
            state_nxt = CH_ENTRY;
          end
        end
      GAP:
        if (cnt == GAP_LAST) state_nxt = INIT;
      INIT:
        if (cnt == INIT_LAST) state_nxt = WAIT;
      WAIT:
        if (wait_end) begin
          if (more) begin
            ch_nxt    = 1'b1;
            state_nxt = CH_ENTRY;
          end else begin
            state_nxt = REPORT;
          end
        end
      REPORT:
      state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN)
      cnt <= '0;
    else if (state_nxt != state)
      cnt <= '0;
    else if (state == GAP || state == INIT)
      cnt <= cnt + 16'd1;

  // pass is settled on REPORT entry so it is valid alongside seq_done
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      en1_q     <= 1'b0;
      err_flags <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      en1_q     <= chan_en[1];
      err_flags <= '0;
      pass      <= (chan_en == 2'b00);
    end else if (wait_end && !abort) begin
      err_flags <= err_n;
      if (!more) pass <= ~|(err_n | tmo_n);
    end

  // Output decode
  always_comb begin
    busy                     = (state != IDLE);
    seq_done                 = (state == REPORT);
    txn.M00_AXI_INIT_AXI_TXN = (state == INIT) && !ch;
    txn.M01_AXI_INIT_AXI_TXN = (state == INIT) && ch;
  end

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Scoreboard bench for axi_txn_sequencer with a behavioural two-master model.
module tb_axi_txn_sequencer;

  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] chan_en = 2'b00;
  logic       busy, seq_done, pass;
  logic [1:0] err_flags, tmo_flags;

  axi_txn_sequencer_if bus();

  axi_txn_sequencer #(
    .GAP_CYCLES(20),
    .INIT_PULSE_CYCLES(2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .start(start),
    .abort(abort),
    .chan_en(chan_en),
    .txn(bus.master),
    .busy(busy),
    .seq_done(seq_done),
    .pass(pass),
    .err_flags(err_flags),
    .tmo_flags(tmo_flags)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // master model: done rises dly cycles after INIT falls, held until next INIT
  int   dly [2] = '{10, 10};
  bit   errv[2] = '{1'b0, 1'b0};
  bit   never[2] = '{1'b0, 1'b0};
  bit   done_r[2] = '{1'b0, 1'b0};
  int   cnt_r[2] = '{0, 0};
  bit   prev_i[2] = '{1'b0, 1'b0};
  logic [1:0] init_v;

  assign init_v = {bus.M01_AXI_INIT_AXI_TXN,
                   bus.M00_AXI_INIT_AXI_TXN};
  assign bus.M00_AXI_TXN_DONE = done_r[0];
  assign bus.M01_AXI_TXN_DONE = done_r[1];
  assign bus.M00_AXI_ERROR = errv[0] & done_r[0];
  assign bus.M01_AXI_ERROR = errv[1] & done_r[1];

  always @(posedge ACLK)
    for (int i = 0; i < 2; i++) begin
      if (init_v[i]) begin
        done_r[i] <= 1'b0;
        cnt_r[i]  <= 0;
      end else if (prev_i[i]) begin
        cnt_r[i] <= never[i] ? 0 : 1;
      end else if (cnt_r[i] > 0) begin
        if (cnt_r[i] >= dly[i]) begin
          done_r[i] <= 1'b1;
          cnt_r[i]  <= 0;
        end else begin
          cnt_r[i] <= cnt_r[i] + 1;
        end
      end
      prev_i[i] <= init_v[i];
    end

  int errors = 0;
  int checks = 0;
  logic [4:0] sbq[$];
  int t0 = 0;
  int i0_first, i0_last, i0_cnt, i1_cnt, n_done, done_cyc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] mk(logic p, logic [1:0] e, logic [1:0] t);
    return {p, e, t};
  endfunction

  // monitor: INIT statistics and scoreboard pop on seq_done
  always @(negedge ACLK) begin
    if (bus.M00_AXI_INIT_AXI_TXN === 1'b1) begin
      if (i0_cnt == 0) i0_first = cyc - t0;
      i0_last = cyc - t0;
      i0_cnt++;
    end
    if (bus.M01_AXI_INIT_AXI_TXN === 1'b1) i1_cnt++;
    if (seq_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_seq_done: got seq_done at cycle %0d expected none", cyc);
      end else begin
        chk("seq_result{pass,err,tmo}",
            {27'd0, pass, err_flags, tmo_flags}, {27'd0, sbq.pop_front()});
      end
    end
  end

  task automatic clear_stats();
    i0_first = -1; i0_last = -1;
    i0_cnt = 0; i1_cnt = 0; n_done = 0; done_cyc = -1;
  endtask

  task automatic pulse_start(bit ab, bit push, logic [4:0] e);
    @(posedge ACLK); #1;
    start = 1'b1;
    abort = ab;
    t0 = cyc;
    if (push) sbq.push_back(e);
    @(posedge ACLK); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge ACLK);
      n++;
    end
    chk(name, sbq.size(), 0);
    repeat (2) @(posedge ACLK);
  endtask

  function automatic logic [31:0] all_out();
    return {23'd0, busy, seq_done, pass, err_flags, tmo_flags,
            bus.M01_AXI_INIT_AXI_TXN, bus.M00_AXI_INIT_AXI_TXN};
  endfunction

  initial begin
    int n;
    clear_stats();
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_outputs", all_out(), 0);
    ARESETN = 1'b1;

    // two channels, no errors
    chan_en = 2'b11;
    clear_stats();
    pulse_start(1'b0, 1'b1, mk(1'b1, 2'b00, 2'b00));
    drain("both_ok_complete", 300);
    chk("both_ok_init0_first", i0_first, 21);
    chk("both_ok_init0_last", i0_last, 22);
    chk("both_ok_init0_len", i0_cnt, 2);
    chk("both_ok_init1_len", i1_cnt, 2);
    chk("both_ok_done_count", n_done, 1);

    // only M01, with error
    chan_en = 2'b10;
    errv[1] = 1'b1;
    clear_stats();
    pulse_start(1'b0, 1'b1, mk(1'b0, 2'b10, 2'b00));
    drain("m01_err_complete", 200);
    chk("m01_err_init0_len", i0_cnt, 0);
    chk("m01_err_init1_len", i1_cnt, 2);
    repeat (5) @(negedge ACLK);
    chk("flags_hold", {29'd0, pass, err_flags}, {29'd0, 1'b0, 2'b10});
    errv[1] = 1'b0;

    // no channel enabled
    chan_en = 2'b00;
    clear_stats();
    pulse_start(1'b0, 1'b1, mk(1'b1, 2'b00, 2'b00));
    drain("empty_complete", 20);
    chk("empty_done_latency", done_cyc - t0, 1);

    // start while busy, then start+abort in IDLE
    chan_en = 2'b11;
    clear_stats();
    pulse_start(1'b0, 1'b1, mk(1'b1, 2'b00, 2'b00));
    repeat (5) @(posedge ACLK);
    pulse_start(1'b0, 1'b0, 5'd0);
    drain("busy_start_complete", 300);
    repeat (10) @(posedge ACLK);
    pulse_start(1'b1, 1'b0, 5'd0);
    repeat (2) @(negedge ACLK);
    chk("start_abort_idle_busy", busy, 0);
    repeat (100) @(posedge ACLK);
    chk("busy_start_done_count", n_done, 1);

    // abort during WAIT of channel 0
    never[0] = 1'b1;
    clear_stats();
    pulse_start(1'b0, 1'b0, 5'd0);
    n = 0;
    while (!(i0_cnt == 2 && bus.M00_AXI_INIT_AXI_TXN == 1'b0) && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    chk("abort_reach_wait", i0_cnt, 2);
    repeat (3) @(negedge ACLK);
    @(posedge ACLK); #1;
    abort = 1'b1;
    @(posedge ACLK); #1;
    abort = 1'b0;
    @(negedge ACLK);
    chk("abort_busy", busy, 0);
    repeat (80) @(posedge ACLK);
    chk("abort_init1_len", i1_cnt, 0);
    chk("abort_done_count", n_done, 0);

`ifdef AXI_TXN_SEQ_TIMEOUT_EN
    // M00 never answers, M01 does
    clear_stats();
    pulse_start(1'b0, 1'b1, mk(1'b0, 2'b00, 2'b01));
    drain("timeout_complete", 400);
    chk("timeout_init1_len", i1_cnt, 2);
`endif
    never[0] = 1'b0;

    // reset during INIT, then a fresh run
    clear_stats();
    pulse_start(1'b0, 1'b1, mk(1'b1, 2'b00, 2'b00));
    n = 0;
    while (bus.M00_AXI_INIT_AXI_TXN !== 1'b1 && n < 60) begin
      @(negedge ACLK);
      n++;
    end
    chk("rst_reach_init", bus.M00_AXI_INIT_AXI_TXN, 1);
    #1 ARESETN = 1'b0;
    #1 chk("reset_mid_init", all_out(), 0);
    sbq.delete();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    clear_stats();
    pulse_start(1'b0, 1'b1, mk(1'b1, 2'b00, 2'b00));
    drain("after_reset_complete", 300);
    chk("after_reset_init0_first", i0_first, 21);
    chk("after_reset_done_count", n_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_txn_sequencer.md
AXI_TXN_SEQUENCER -- requirements
Module: axi_txn_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 20, idle cycles before each INIT pulse; legal range 0..65535, where 0 skips the gap.
REQ-002 Parameter INIT_PULSE_CYCLES, default 2, INIT high time in cycles; legal range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096, maximum WAIT cycles per channel; legal range 1..1048575.
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESETN  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  single-cycle request to run one sequence.
REQ-007 abort  in  1  cancels a running sequence.
REQ-008 chan_en  in  2  per-channel enable; bit0 = M00, bit1 = M01.
REQ-009 M00_AXI_INIT_AXI_TXN / M01_AXI_INIT_AXI_TXN  out  1 each  INIT pulse to master channel 0/1.
REQ-010 M00_AXI_TXN_DONE / M01_AXI_TXN_DONE  in  1 each  done level from master 0/1.
REQ-011 M00_AXI_ERROR / M01_AXI_ERROR  in  1 each  error level from master 0/1, valid with done.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 seq_done  out  1  one-cycle pulse when a sequence completes.
REQ-014 pass  out  1  high when the last completed sequence had no error and no timeout.
REQ-015 err_flags  out  2  per-channel ERROR captured at done.
REQ-016 tmo_flags  out  2  per-channel timeout flags.

Function
REQ-017 FSM states: IDLE, GAP, INIT, WAIT, REPORT; all registered outputs.
REQ-018 start is accepted only in IDLE; start in any other state is ignored.
REQ-019 On acceptance: err_flags, tmo_flags and pass clear; current channel = lowest enabled bit; FSM enters GAP on the next cycle.
REQ-020 Start with chan_en = 00: FSM goes IDLE -> REPORT; seq_done pulses on the cycle after start; pass = 1.
REQ-021 GAP lasts exactly GAP_CYCLES cycles; with GAP_CYCLES = 0 the FSM enters INIT directly from acceptance.
REQ-022 INIT drives the current channel's INIT output high for exactly INIT_PULSE_CYCLES cycles; the other INIT output stays low.
REQ-023 WAIT samples only the current channel's TXN_DONE; DONE during GAP or INIT is ignored.
REQ-024 DONE high in WAIT: err_flags[ch] <= ERROR sampled in the same cycle; then the next enabled channel enters GAP, or the FSM enters REPORT if none remains.
REQ-025 Channel order is fixed: 0 before 1; disabled channels are skipped with zero cycles spent.
REQ-026 REPORT lasts 1 cycle: seq_done = 1 and pass = ~|(err_flags | tmo_flags); FSM then returns to IDLE.
REQ-027 Flags and pass hold until the next accepted start.
REQ-028 abort in any non-IDLE state: FSM enters IDLE next cycle; INIT outputs go low; no seq_done; flags keep their partial values.
REQ-029 abort and start together in IDLE: abort wins and start is ignored.
REQ-030 A done level still high from the previous channel does not affect the next channel, because only the current channel is sampled.

Reset
REQ-031 While ARESETN = 0: FSM in IDLE; both INIT outputs, busy, seq_done, pass, err_flags and tmo_flags are 0; all counters are 0.
REQ-032 Reset asserted mid-sequence forces those values immediately, with no seq_done.
REQ-033 After deassertion the FSM accepts start from the first rising edge.

Configuration
REQ-034 Macro AXI_TXN_SEQ_TIMEOUT_EN defined: a 20-bit counter starts at WAIT entry; if it reaches TIMEOUT_CYCLES with DONE low, tmo_flags[ch] is set, err_flags[ch] stays 0, and the FSM advances as in REQ-024.
REQ-035 Macro AXI_TXN_SEQ_TIMEOUT_EN undefined: WAIT has no limit, tmo_flags is tied to 00, and no timeout counter is instantiated.

Verification
REQ-036 Defaults, chan_en = 11, start at cycle 0, each master done with ERROR = 0 10 cycles after its INIT falls -> M00 INIT high on cycles 21-22; one seq_done; pass = 1; err_flags = 00.
REQ-037 chan_en = 10, M01 done with ERROR = 1 -> M00 INIT never asserted; err_flags = 10; pass = 0.
REQ-038 Macro defined, TIMEOUT_CYCLES = 50, M00 never done, M01 done -> tmo_flags = 01; M01 INIT asserted; pass = 0.
REQ-039 abort in WAIT of channel 0 -> IDLE next cycle; busy = 0; no seq_done; M01 INIT never asserted.
REQ-040 start while busy, and start + abort together in IDLE -> both ignored; exactly one seq_done per accepted start.
REQ-041 ARESETN pulled low during INIT -> INIT output low within the same cycle; all outputs 0; a fresh start completes normally.
